// File: rtl/video_timing_gen.sv
// Raster timing and frame-buffer fetch generator; sync/DE/RGB are realigned to the read latency.
// Optional colour-bar source: define VTG_TEST_PATTERN_EN to add the test_mode input.
module video_timing_gen #(
  parameter int   H_PIXEL   = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_PIXEL   = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter logic HS_POL    = 1'b0,
  parameter logic VS_POL    = 1'b0,
  parameter int   ADDR_W    = 21,
  parameter int   STRIDE    = 640,
  parameter int   BASE_ADDR = 0,
  parameter int   RD_LAT    = 2
) (
  input  logic              clk_low,
  input  logic              reset,
  input  logic              enable,
`ifdef VTG_TEST_PATTERN_EN
  input  logic              test_mode,
`endif
  input  logic [7:0]        pix_r_in,
  input  logic [7:0]        pix_g_in,
  input  logic [7:0]        pix_b_in,
  output logic [ADDR_W-1:0] addr,
  output logic              rd_en,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [7:0]        r_out,
  output logic [7:0]        g_out,
  output logic [7:0]        b_out,
  output logic              line_start,
  output logic              frame_start,
  output logic              busy
);

  localparam int H_TOT = H_PIXEL + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_PIXEL + V_FP + V_SYNC + V_BP;
  localparam int CXW   = $clog2(H_TOT);
  localparam int CYW   = $clog2(V_TOT);
  localparam int DL    = (RD_LAT > 1) ? RD_LAT - 1 : 1;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(STRIDE);
`ifdef VTG_TEST_PATTERN_EN
  localparam int SW = 5 + CXW;
`else
  localparam int SW = 5;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t            state;
  logic [CXW-1:0]    cx;
  logic [CXW-1:0]    nx;
  logic [CYW-1:0]    cy;
  logic [CYW-1:0]    ny;
  logic              last_x;
  logic              last_y;
  logic [ADDR_W-1:0] line_base;
  logic [2:0]        drain_cnt;
  logic              fetch_ok;
  logic [SW-1:0]     stage;
  logic [SW-1:0]     next_stage;
  logic [SW-1:0]     origin_stage;
  logic [SW-1:0]     pre;
  logic [SW-1:0]     dl [DL];
  logic [23:0]       rgb;

  // Stage bits: 0 act, 1 hs, 2 vs, 3 line strobe, 4 frame strobe, [SW-1:5] cx for the bar generator.
  function automatic logic [SW-1:0] raw_timing(input logic [CXW-1:0] x, input logic [CYW-1:0] y);
    logic [SW-1:0] s;
    s    = '0;
    s[0] = (x < CXW'(H_PIXEL)) && (y < CYW'(V_PIXEL));
    s[1] = (x >= CXW'(H_PIXEL + H_FP)) && (x < CXW'(H_PIXEL + H_FP + H_SYNC));
    s[2] = (y >= CYW'(V_PIXEL + V_FP)) && (y < CYW'(V_PIXEL + V_FP + V_SYNC));
    s[3] = (x == CXW'(0)) && (y < CYW'(V_PIXEL));
    s[4] = (x == CXW'(0)) && (y == CYW'(0));
`ifdef VTG_TEST_PATTERN_EN
    s[SW-1:5] = x;
`endif
    return s;
  endfunction

`ifdef VTG_TEST_PATTERN_EN
  // Bar order white..black maps onto inverted index bits: r=~i[1], g=~i[2], b=~i[0].
  function automatic logic [23:0] bar_rgb(input logic [CXW-1:0] x);
    logic [2:0] idx;
    idx = 3'((32'(x) * 32'd8) / 32'(H_PIXEL));
    return {{8{~idx[1]}}, {8{~idx[2]}}, {8{~idx[0]}}};
  endfunction
`endif

  // Next raster position and the fetch-stage timing it produces.
  always_comb begin
    last_x = (cx == CXW'(H_TOT - 1));
    last_y = (cy == CYW'(V_TOT - 1));
    if (last_x) begin
      nx = CXW'(0);
      ny = last_y ? CYW'(0) : cy + CYW'(1);
    end else begin
      nx = cx + CXW'(1);
      ny = cy;
    end
    next_stage   = raw_timing(nx, ny);
    origin_stage = raw_timing(CXW'(0), CYW'(0));
`ifdef VTG_TEST_PATTERN_EN
    fetch_ok = ~test_mode;
`else
    fetch_ok = 1'b1;
`endif
  end

  // Run-control FSM with raster counters, incremental address generator and fetch outputs.
  always_ff @(posedge clk_low) begin
    if (reset) begin
      state     <= IDLE;
      cx        <= CXW'(0);
      cy        <= CYW'(0);
      line_base <= BASE;
      addr      <= BASE;
      rd_en     <= 1'b0;
      busy      <= 1'b0;
      stage     <= '0;
      drain_cnt <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          cx        <= CXW'(0);
          cy        <= CYW'(0);
          line_base <= BASE;
          addr      <= BASE;
          if (enable) begin
            state <= RUN;
            busy  <= 1'b1;
            stage <= origin_stage;
            rd_en <= origin_stage[0] & fetch_ok;
          end else begin
            busy  <= 1'b0;
            stage <= '0;
            rd_en <= 1'b0;
          end
        end
        RUN: begin
          cx   <= nx;
          cy   <= ny;
          busy <= 1'b1;
          if (last_x) begin
            if (last_y) begin
              line_base <= BASE;
              addr      <= BASE;
            end else begin
              line_base <= line_base + STEP;
              addr      <= line_base + STEP;
            end
          end else if (nx < CXW'(H_PIXEL)) begin
            addr <= addr + ADDR_W'(1);
          end
          // A stop request is honoured only on the last pixel of the frame.
          if (last_x && last_y && !enable) begin
            state     <= DRAIN;
            stage     <= '0;
            rd_en     <= 1'b0;
            drain_cnt <= 3'd0;
          end else begin
            stage <= next_stage;
            rd_en <= next_stage[0] & fetch_ok;
          end
        end
        DRAIN: begin
          if (drain_cnt == 3'(RD_LAT - 1)) begin
            if (enable) begin
              state <= RUN;
              stage <= origin_stage;
              rd_en <= origin_stage[0] & fetch_ok;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            drain_cnt <= drain_cnt + 3'd1;
          end
        end
        default: begin
          state <= IDLE;
          stage <= '0;
          rd_en <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Delay line carrying fetch-stage timing towards the returned pixel data.
  always_ff @(posedge clk_low) begin
    if (reset) begin
      for (int i = 0; i < DL; i++) dl[i] <= '0;
    end else begin
      dl[0] <= stage;
      for (int i = 1; i < DL; i++) dl[i] <= dl[i-1];
    end
  end

  // Tap one cycle short of RD_LAT; the output register supplies the last cycle.
  always_comb begin
    if (RD_LAT > 1) pre = dl[DL-1];
    else            pre = stage;
    rgb = 24'h000000;
`ifdef VTG_TEST_PATTERN_EN
    if (pre[0] && test_mode) rgb = bar_rgb(pre[SW-1:5]);
    else if (pre[0])         rgb = {pix_r_in, pix_g_in, pix_b_in};
    else                     rgb = 24'h000000;
`else
    if (pre[0]) rgb = {pix_r_in, pix_g_in, pix_b_in};
    else        rgb = 24'h000000;
`endif
  end

  // Aligned video output register.
  always_ff @(posedge clk_low) begin
    if (reset) begin
      de          <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      r_out       <= 8'h00;
      g_out       <= 8'h00;
      b_out       <= 8'h00;
    end else begin
      de          <= pre[0];
      hsync       <= pre[1] ? HS_POL : ~HS_POL;
      vsync       <= pre[2] ? VS_POL : ~VS_POL;
      line_start  <= pre[3];
      frame_start <= pre[4];
      {r_out, g_out, b_out} <= rgb;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a tiny 8x6 raster (4x3 active, stride 8, base 16).
module tb_video_timing_gen;

  localparam int ADDR_W = 21;

  logic              clk_low = 1'b0;
  logic              reset   = 1'b1;
  logic              enable  = 1'b0;
  logic [7:0]        pix_r_in, pix_g_in, pix_b_in;
  logic [ADDR_W-1:0] addr;
  logic              rd_en, hsync, vsync, de, line_start, frame_start, busy;
  logic [7:0]        r_out, g_out, b_out;
  logic [7:0]        mem_q = 8'h00;
  int                cyc = 0;
  int                n_tests = 0;
  int                n_fail = 0;
  int                pos = 0;

  typedef struct {
    int                due;
    logic              act;
    logic [ADDR_W-1:0] addr;
    logic              de, hs, vs, ls, fs;
    logic [7:0]        r, g, b;
  } exp_t;

  exp_t sb[$];

  video_timing_gen #(
    .H_PIXEL(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_PIXEL(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .ADDR_W(ADDR_W),
    .STRIDE(8), .BASE_ADDR(16), .RD_LAT(2)
  ) dut (
    .clk_low(clk_low), .reset(reset), .enable(enable),
`ifdef VTG_TEST_PATTERN_EN
    .test_mode(1'b0),
`endif
    .pix_r_in(pix_r_in), .pix_g_in(pix_g_in), .pix_b_in(pix_b_in),
    .addr(addr), .rd_en(rd_en), .hsync(hsync), .vsync(vsync), .de(de),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .line_start(line_start), .frame_start(frame_start), .busy(busy)
  );

  always #5 clk_low = ~clk_low;

  // Frame buffer: registered read returning bytes derived from the address.
  always @(posedge clk_low) begin
    cyc   <= cyc + 1;
    mem_q <= addr[7:0];
  end
  assign pix_r_in = mem_q;
  assign pix_g_in = ~mem_q;
  assign pix_b_in = mem_q ^ 8'h5A;

  // Expected behaviour of raster position k (8 wide, 6 tall); live=0 means idle/drain.
  function automatic exp_t model(int k, bit live);
    exp_t m;
    int x, y;
    x      = k % 8;
    y      = (k / 8) % 6;
    m.due  = 0;
    m.act  = live && (x < 4) && (y < 3);
    m.addr = ADDR_W'(16 + y * 8 + x);
    m.de   = m.act;
    m.hs   = !(live && (x >= 5) && (x <= 6));
    m.vs   = !(live && (y == 4));
    m.ls   = live && (x == 0) && (y < 3);
    m.fs   = live && (x == 0) && (y == 0);
    m.r    = m.act ? m.addr[7:0] : 8'h00;
    m.g    = m.act ? ~m.addr[7:0] : 8'h00;
    m.b    = m.act ? (m.addr[7:0] ^ 8'h5A) : 8'h00;
    return m;
  endfunction

  task automatic scoreboard_monitor();
    exp_t e;
    forever begin
      @(negedge clk_low);
      if (sb.size() > 0 && sb[0].due < cyc) begin
        n_tests++; n_fail++;
        $display("FAIL sb_stale cyc=%0d entry due=%0d never compared", cyc, sb[0].due);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        n_tests++;
        if ({de, hsync, vsync, line_start, frame_start, r_out, g_out, b_out} !==
            {e.de, e.hs, e.vs, e.ls, e.fs, e.r, e.g, e.b}) begin
          n_fail++;
          $display("FAIL aligned cyc=%0d got de=%b hs=%b vs=%b ls=%b fs=%b rgb=%h_%h_%h exp de=%b hs=%b vs=%b ls=%b fs=%b rgb=%h_%h_%h",
                   cyc, de, hsync, vsync, line_start, frame_start, r_out, g_out, b_out,
                   e.de, e.hs, e.vs, e.ls, e.fs, e.r, e.g, e.b);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0;
    repeat (3) @(negedge clk_low);
    reset = 1'b0;
    repeat (2) @(negedge clk_low);
    n_tests++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en got=%b exp=0", rd_en); end
    n_tests++; if (addr !== 21'd16) begin n_fail++; $display("FAIL reset_addr got=%0d exp=16", addr); end
    n_tests++; if ({de, r_out, g_out, b_out} !== 25'd0) begin n_fail++; $display("FAIL reset_de_rgb got=%b %h%h%h exp=0", de, r_out, g_out, b_out); end
    n_tests++; if ({hsync, vsync} !== 2'b11) begin n_fail++; $display("FAIL reset_sync got=%b%b exp=11", hsync, vsync); end
    n_tests++; if ({busy, line_start, frame_start} !== 3'b000) begin n_fail++; $display("FAIL reset_busy_strobes got=%b%b%b exp=000", busy, line_start, frame_start); end
  endtask

  task automatic test_frame();
    exp_t m;
    int n_rd, n_ls, n_fs;
    n_rd = 0; n_ls = 0; n_fs = 0;
    enable = 1'b1;
    for (int k = 0; k < 96; k++) begin
      @(negedge clk_low);
      m = model(k, 1'b1);
      n_tests++; if (rd_en !== m.act) begin n_fail++; $display("FAIL frame_rd_en pos=%0d got=%b exp=%b", k, rd_en, m.act); end
      if (m.act) begin
        n_tests++; if (addr !== m.addr) begin n_fail++; $display("FAIL frame_addr pos=%0d got=%0d exp=%0d", k, addr, m.addr); end
      end
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL frame_busy pos=%0d got=%b exp=1", k, busy); end
      m.due = cyc + 2;
      sb.push_back(m);
      if (rd_en === 1'b1) n_rd++;
      if (line_start === 1'b1) n_ls++;
      if (frame_start === 1'b1) n_fs++;
    end
    pos = 96;
    n_tests++; if (n_rd != 24) begin n_fail++; $display("FAIL frame_rd_count got=%0d exp=24", n_rd); end
    n_tests++; if (n_ls != 6) begin n_fail++; $display("FAIL frame_line_start_count got=%0d exp=6", n_ls); end
    n_tests++; if (n_fs != 2) begin n_fail++; $display("FAIL frame_start_count got=%0d exp=2", n_fs); end
  endtask

  task automatic test_drain();
    exp_t m;
    for (int k = pos; k < 144; k++) begin
      @(negedge clk_low);
      m = model(k, 1'b1);
      n_tests++; if (rd_en !== m.act) begin n_fail++; $display("FAIL drain_run_rd_en pos=%0d got=%b exp=%b", k, rd_en, m.act); end
      if (m.act) begin
        n_tests++; if (addr !== m.addr) begin n_fail++; $display("FAIL drain_run_addr pos=%0d got=%0d exp=%0d", k, addr, m.addr); end
      end
      m.due = cyc + 2;
      sb.push_back(m);
      if (k == 104) enable = 1'b0;
    end
    for (int d = 0; d < 2; d++) begin
      @(negedge clk_low);
      m = model(0, 1'b0);
      n_tests++; if ({rd_en, busy} !== 2'b01) begin n_fail++; $display("FAIL drain_cycle%0d got rd_en=%b busy=%b exp rd_en=0 busy=1", d, rd_en, busy); end
      m.due = cyc + 2;
      sb.push_back(m);
    end
    @(negedge clk_low);
    m = model(0, 1'b0);
    n_tests++; if ({rd_en, busy} !== 2'b00) begin n_fail++; $display("FAIL drain_idle got rd_en=%b busy=%b exp 00", rd_en, busy); end
    n_tests++; if (addr !== 21'd16) begin n_fail++; $display("FAIL drain_idle_addr got=%0d exp=16", addr); end
    m.due = cyc + 2;
    sb.push_back(m);
    enable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_low);
      m = model(k, 1'b1);
      n_tests++; if (rd_en !== m.act) begin n_fail++; $display("FAIL restart_rd_en pos=%0d got=%b exp=%b", k, rd_en, m.act); end
      if (m.act) begin
        n_tests++; if (addr !== m.addr) begin n_fail++; $display("FAIL restart_addr pos=%0d got=%0d exp=%0d", k, addr, m.addr); end
      end
      m.due = cyc + 2;
      sb.push_back(m);
    end
    pos = 10;
  endtask

  task automatic test_reset_mid();
    exp_t m;
    @(negedge clk_low);
    m = model(pos, 1'b1);
    n_tests++; if ({rd_en, addr} !== {1'b1, m.addr}) begin n_fail++; $display("FAIL mid_pre_reset got rd_en=%b addr=%0d exp rd_en=1 addr=%0d", rd_en, addr, m.addr); end
    reset = 1'b1;
    while (sb.size() > 0 && sb[sb.size()-1].due > cyc) void'(sb.pop_back());
    for (int d = 1; d <= 3; d++) begin
      m = model(0, 1'b0);
      m.due = cyc + d;
      sb.push_back(m);
    end
    @(negedge clk_low);
    reset = 1'b0;
    n_tests++; if ({rd_en, de, busy} !== 3'b000) begin n_fail++; $display("FAIL mid_reset_ctrl got rd_en=%b de=%b busy=%b exp 000", rd_en, de, busy); end
    n_tests++; if (addr !== 21'd16) begin n_fail++; $display("FAIL mid_reset_addr got=%0d exp=16", addr); end
    n_tests++; if ({hsync, vsync} !== 2'b11) begin n_fail++; $display("FAIL mid_reset_sync got=%b%b exp=11", hsync, vsync); end
    for (int k = 0; k < 50; k++) begin
      @(negedge clk_low);
      m = model(k, 1'b1);
      n_tests++; if (rd_en !== m.act) begin n_fail++; $display("FAIL mid_restart_rd_en pos=%0d got=%b exp=%b", k, rd_en, m.act); end
      if (m.act) begin
        n_tests++; if (addr !== m.addr) begin n_fail++; $display("FAIL mid_restart_addr pos=%0d got=%0d exp=%0d", k, addr, m.addr); end
      end
      m.due = cyc + 2;
      sb.push_back(m);
    end
  endtask

  task automatic test_scoreboard_empty();
    enable = 1'b0;
    repeat (4) @(negedge clk_low);
    n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_leftover got=%0d entries exp=0", sb.size()); end
  endtask

  initial begin
    fork
      scoreboard_monitor();
    join_none
    test_reset();
    test_frame();
    test_drain();
    test_reset_mid();
    test_scoreboard_empty();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised raster timing and framebuffer-fetch generator; successor to the fixed-timing counter front end of the HDMI transmitter path.
- Produces pixel-read addresses for the frame buffer, accounts for configurable memory read latency, and emits hsync/vsync/DE/RGB aligned to the returned data.
- Output feeds the TMDS encoders directly.
- Adds over the previous generation:
  - independent sync widths and polarities
  - line stride and base address
  - enable/stop-at-frame-end control
  - line/frame strobes

Parameters:
H_PIXEL, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_PIXEL, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level
ADDR_W, 21, address width
STRIDE, 640, address increment per active line (must be >= H_PIXEL)
BASE_ADDR, 0, address of pixel (0,0)
RD_LAT, 2, frame-buffer read latency in clk_low cycles (1..8)

Ports:
clk_low  in  1  pixel clock
reset  in  1  synchronous, active-high
enable  in  1  run request
pix_r_in  in  8  red from frame buffer, valid RD_LAT cycles after rd_en
pix_g_in  in  8  green from frame buffer
pix_b_in  in  8  blue from frame buffer
addr  out  ADDR_W  read address
rd_en  out  1  read strobe, high for each active pixel
hsync  out  1  aligned horizontal sync
vsync  out  1  aligned vertical sync
de  out  1  aligned data enable
r_out  out  8  aligned red
g_out  out  8  aligned green
b_out  out  8  aligned blue
line_start  out  1  one-cycle pulse coincident with first DE of each active line
frame_start  out  1  one-cycle pulse coincident with first DE of each frame
busy  out  1  high while a frame is being scanned

Behaviour:
- Derived totals: H_TOT = H_PIXEL+H_FP+H_SYNC+H_BP; V_TOT = V_PIXEL+V_FP+V_SYNC+V_BP.
- Counters:
  - cx runs 0..H_TOT-1; cy runs 0..V_TOT-1.
  - cy advances when cx wraps; both wrap to 0.
- Raw (fetch-stage) timing:
  - act = (cx < H_PIXEL) && (cy < V_PIXEL)
  - hs_raw active when H_PIXEL+H_FP <= cx < H_PIXEL+H_FP+H_SYNC
  - vs_raw active when V_PIXEL+V_FP <= cy < V_PIXEL+V_FP+V_SYNC; vs_raw changes only at cx == 0.
- Fetch: rd_en = act (registered, same cycle as addr).
- Address generation:
  - addr starts at BASE_ADDR for (0,0) and increments by 1 per active pixel.
  - At the start of each active line, addr = line_base, where line_base = BASE_ADDR + cy*STRIDE, computed incrementally (add STRIDE per line, no multiplier).
  - At frame wrap, line_base returns to BASE_ADDR.
  - Arithmetic is modulo 2^ADDR_W.
- Alignment:
  - act, hs_raw, vs_raw and the strobes pass through an RD_LAT-deep shift register, so de/hsync/vsync appear exactly RD_LAT cycles after the corresponding rd_en cycle.
  - r/g/b_out = pix_*_in when the delayed act is 1, else 0. Registered, so total latency from rd_en to de/RGB is RD_LAT.
- Sync polarity: hsync = delayed hs_raw XNOR HS_POL (i.e. equals HS_POL when active). vsync likewise with VS_POL.
- Strobes:
  - line_start when delayed (cx == 0 && cy < V_PIXEL).
  - frame_start when delayed (cx == 0 && cy == 0).
- State machine:
  - IDLE:
    - Counters held at 0, rd_en = 0, busy = 0.
    - Outputs: de = 0, RGB = 0, hsync/vsync at inactive level.
    - enable = 1 → RUN on next edge; first rd_en occurs in that cycle (cx = 0, cy = 0).
  - RUN:
    - busy = 1, counters free-run.
    - If enable = 0 when cx = H_TOT-1 and cy = V_TOT-1 → DRAIN; else continue.
    - enable deasserted mid-frame does not truncate the frame.
  - DRAIN:
    - Hold counters for RD_LAT cycles so the delay line empties, then → IDLE.
    - enable = 1 in DRAIN → RUN at the end of the drain.
- Reset:
  - Any cycle, including mid-frame or mid-drain, forces IDLE on the next edge.
  - Clears all counters, addr = BASE_ADDR, the delay line, all strobes and RGB.
  - Sync outputs go to inactive level.

Optional Feature:
- Macro VTG_TEST_PATTERN_EN.
- Defined:
  - Adds input test_mode (1 bit).
  - When test_mode = 1, RGB is replaced by 8 vertical colour bars computed from the delayed cx: bar index = cx*8/H_PIXEL. Order: white, yellow, cyan, green, magenta, red, blue, black; full-scale 8'hFF / 8'h00.
  - rd_en is forced to 0; timing and strobes are unchanged.
- Undefined: no test_mode port; RGB always comes from pix_*_in.

Test Plan:
- Shared params: H_PIXEL=4, H_FP=1, H_SYNC=2, H_BP=1, V_PIXEL=3, V_FP=1, V_SYNC=1, V_BP=1, RD_LAT=2, STRIDE=8, BASE_ADDR=16, polarity 0.
- Reset, then enable = 1 → rd_en high 4 of every 8 cycles; addr sequence 16,17,18,19 / 24..27 / 32..35, then back to 16 next frame.
- Memory model returns pix = addr[7:0] → de and r_out rise exactly 2 cycles after rd_en; r_out = 16,17,18,19 on first line; RGB = 0 while de = 0.
- Check sync → hsync low on cx 5–6 (delayed by 2); vsync low for the whole of line cy = 4; frame_start once per 48 cycles, line_start 3 times per frame.
- Drop enable at cy = 1 → frame completes, 2 drain cycles, busy falls, outputs idle; re-enable → next frame_start at addr 16.
- Assert reset for 1 cycle at cx = 2, cy = 1 → next cycle de = 0, rd_en = 0, addr = 16, hsync/vsync = 1; enable held high → restart at (0,0).
- With VTG_TEST_PATTERN_EN and test_mode = 1 and H_PIXEL=8 → r_out sequence FF,FF,00,00,FF,FF,00,00 per line; rd_en = 0.
